seq_unsigned_divider: RTL and testbench

- Parametrised, iterative, restoring unsigned divider: WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and remainder.
- Successor to the single-cycle 4-bit divider: generic width, start/busy/done handshake, one quotient bit per cycle, explicit divide-by-zero flag.
- Sits behind the tile I/O wrapper, which drives operands and start and samples the results.

---
 rtl/seq_unsigned_divider_if.sv | 31 +++
 rtl/seq_unsigned_divider.sv | 132 +++++++++++++
 tb/tb_seq_unsigned_divider.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_unsigned_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_unsigned_divider_if
// Brief    : Operand/start/result bundle between the tile I/O wrapper and the
//            sequential unsigned divider.
// Revision : 1.0
// ============================================================================
interface seq_unsigned_divider_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output ena, start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  ena, start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_unsigned_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_unsigned_divider
// Brief    : Iterative restoring unsigned divider, one quotient bit per cycle,
//            start/busy/done handshake. Define DIVU_EARLY_OUT_EN to finish in
//            one cycle when divisor > dividend.
// Revision : 1.0
// ============================================================================
module seq_unsigned_divider #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_unsigned_divider_if.slave  bus
);
    localparam int              CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prem_q,  prem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    // The partial remainder is always below the divisor between steps, so it
    // fits WIDTH bits; only the shifted value needs the extra top bit.
    logic [WIDTH:0]   prem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] shreg_next;

    assign prem_shift = {prem_q, shreg_q[WIDTH-1]};
    assign trial      = prem_shift - {1'b0, dvs_q};
    assign q_bit      = ~trial[WIDTH];
    assign prem_next  = q_bit ? trial[WIDTH-1:0] : prem_shift[WIDTH-1:0];
    assign shreg_next = {shreg_q[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prem_q  <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        if (bus.ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        dvs_d = bus.divisor;
                        if (bus.divisor == '0) begin
                            state_d = S_DONE;
                            quo_d   = '1;
                            rem_d   = bus.dividend;
                            dbz_d   = 1'b1;
`ifdef DIVU_EARLY_OUT_EN
                        end else if (bus.divisor > bus.dividend) begin
                            state_d = S_DONE;
                            quo_d   = '0;
                            rem_d   = bus.dividend;
                            dbz_d   = 1'b0;
`endif
                        end else begin
                            state_d = S_CALC;
                            prem_d  = '0;
                            shreg_d = bus.dividend;
                            cnt_d   = '0;
                            dbz_d   = 1'b0;
                        end
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    prem_d  = prem_next;
                    shreg_d = shreg_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST) begin
                        state_d = S_DONE;
                        quo_d   = shreg_next;
                        rem_d   = prem_next;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state_q == S_CALC);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_unsigned_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_unsigned_divider
// Brief    : Directed self-checking bench for seq_unsigned_divider (WIDTH 8 and 16).
// Revision : 1.0
// ============================================================================
module tb_seq_unsigned_divider;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    seq_unsigned_divider_if #(.WIDTH(8))  bus8 ();
    seq_unsigned_divider_if #(.WIDTH(16)) bus16 ();

    seq_unsigned_divider #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    seq_unsigned_divider #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVU_EARLY_OUT_EN
    localparam int C_EARLY_LAT = 0;
    localparam int C_B2B_LAT   = 1;
`else
    localparam int C_EARLY_LAT = 8;
    localparam int C_B2B_LAT   = 9;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called on a falling edge: present a request for exactly one rising edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        bus8.dividend = a;
        bus8.divisor  = b;
        bus8.start    = 1'b1;
        @(negedge clk);
        bus8.start    = 1'b0;
    endtask

    // Counts falling edges after the accepting edge until done (bounded).
    task automatic wait_done(input int maxc, output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (!bus8.done && cyc < maxc) begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int  cyc;
        int  busy_n;
        logic seen;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus8.ena = 1'b1;   bus8.start = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
        bus16.ena = 1'b1;  bus16.start = 1'b0; bus16.dividend = '0; bus16.divisor = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 0);
        chk("rst_done", 32'(bus8.done), 0);
        chk("rst_quo",  32'(bus8.quotient), 0);
        chk("rst_rem",  32'(bus8.remainder), 0);
        chk("rst_dbz",  32'(bus8.div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 200 / 7
        launch(8'd200, 8'd7);
        wait_done(40, cyc, busy_n);
        chk("d1_busy_cycles", 32'(busy_n), 8);
        chk("d1_latency",     32'(cyc), 8);
        chk("d1_done",        32'(bus8.done), 1);
        chk("d1_busy_in_done", 32'(bus8.busy), 0);
        chk("d1_quo",         32'(bus8.quotient), 28);
        chk("d1_rem",         32'(bus8.remainder), 4);
        chk("d1_dbz",         32'(bus8.div_by_zero), 0);
        @(negedge clk);
        chk("d1_done_pulse",  32'(bus8.done), 0);

        // 255 / 1 then 0 / 13 with start held through DONE
        bus8.dividend = 8'd255; bus8.divisor = 8'd1; bus8.start = 1'b1;
        @(negedge clk);
        bus8.dividend = 8'd0;   bus8.divisor = 8'd13;
        wait_done(40, cyc, busy_n);
        chk("b2b_quo1", 32'(bus8.quotient), 255);
        chk("b2b_rem1", 32'(bus8.remainder), 0);
        @(negedge clk);
        bus8.start = 1'b0;
        cyc = 1;
        while (!bus8.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_gap",  32'(cyc), C_B2B_LAT);
        chk("b2b_quo2", 32'(bus8.quotient), 0);
        chk("b2b_rem2", 32'(bus8.remainder), 0);
        @(negedge clk);

        // 77 / 0, then 9 / 3 clears the flag
        launch(8'd77, 8'd0);
        wait_done(40, cyc, busy_n);
        chk("dz_latency", 32'(cyc), 0);
        chk("dz_quo",     32'(bus8.quotient), 255);
        chk("dz_rem",     32'(bus8.remainder), 77);
        chk("dz_flag",    32'(bus8.div_by_zero), 1);
        launch(8'd9, 8'd3);
        chk("dz_clear_on_start", 32'(bus8.div_by_zero), 0);
        wait_done(40, cyc, busy_n);
        chk("d93_quo", 32'(bus8.quotient), 3);
        chk("d93_rem", 32'(bus8.remainder), 0);
        @(negedge clk);

        // Reset on the fourth CALC cycle of 100 / 3
        launch(8'd100, 8'd3);
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", 32'(bus8.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus8.busy), 0);
        chk("mrst_done", 32'(bus8.done), 0);
        chk("mrst_quo",  32'(bus8.quotient), 0);
        chk("mrst_rem",  32'(bus8.remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) seen = 1'b1;
        end
        chk("mrst_no_done", 32'(seen), 0);
        launch(8'd100, 8'd3);
        wait_done(40, cyc, busy_n);
        chk("d100_quo", 32'(bus8.quotient), 33);
        chk("d100_rem", 32'(bus8.remainder), 1);
        @(negedge clk);

        // 150 / 11 with a five-cycle enable stall and input noise during CALC
        launch(8'd150, 8'd11);
        repeat (3) @(negedge clk);
        bus8.ena = 1'b0; bus8.start = 1'b1; bus8.dividend = 8'd1; bus8.divisor = 8'd1;
        repeat (5) @(negedge clk);
        chk("stall_busy", 32'(bus8.busy), 1);
        chk("stall_done", 32'(bus8.done), 0);
        chk("stall_quo",  32'(bus8.quotient), 33);
        chk("stall_rem",  32'(bus8.remainder), 1);
        bus8.ena = 1'b1; bus8.start = 1'b0;
        wait_done(40, cyc, busy_n);
        chk("stall_latency", 32'(cyc), 5);
        chk("d150_quo", 32'(bus8.quotient), 13);
        chk("d150_rem", 32'(bus8.remainder), 7);
        bus8.ena = 1'b0;
        @(negedge clk);
        chk("done_held_no_ena", 32'(bus8.done), 1);
        bus8.ena = 1'b1;
        @(negedge clk);
        chk("done_clears_after_ena", 32'(bus8.done), 0);

        // 5 / 9: divisor above dividend
        launch(8'd5, 8'd9);
        wait_done(40, cyc, busy_n);
        chk("small_latency", 32'(cyc), C_EARLY_LAT);
        chk("small_quo",     32'(bus8.quotient), 0);
        chk("small_rem",     32'(bus8.remainder), 5);
        chk("small_dbz",     32'(bus8.div_by_zero), 0);

        // WIDTH=16: 60000 / 123
        bus16.dividend = 16'd60000; bus16.divisor = 16'd123; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        cyc = 0;
        while (!bus16.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("w16_latency", 32'(cyc), 16);
        chk("w16_quo",     32'(bus16.quotient), 487);
        chk("w16_rem",     32'(bus16.remainder), 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
